// File: rtl/sd_resp_pkg.sv
// sd_resp_pkg: shared state type and sector constants for the SD block responder.
package sd_resp_pkg;
    typedef enum logic [2:0] {IDLE, DELAY, RD_XFER, WR_XFER, DONE, MNT} sd_state_t;
    localparam int SECTOR_WORDS = 256;
    localparam logic [15:0] FILL_WORD = 16'hFFFF;
endpackage

// File: rtl/sd_word_pipe.sv
// sd_word_pipe: word counter and 1-cycle store/buffer alignment for sector transfers.
// SD_THROTTLE_EN inserts one idle cycle between words in both directions.
module sd_word_pipe
    import sd_resp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic          rd_i,
    input  logic          wr_i,
    input  logic          ok_i,
    input  logic [AW-9:0] lba_i,
    input  logic [15:0]   st_rdata_i,
    input  logic [15:0]   buff_din_i,
    output logic          done_o,
    output logic [AW-1:0] st_addr_o,
    output logic          st_rd_o,
    output logic          st_wr_o,
    output logic [15:0]   st_wdata_o,
    output logic [7:0]    buff_addr_o,
    output logic [15:0]   buff_dout_o,
    output logic          buff_wr_o
);
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] idx_q, addr_q, addr_d;
    logic       p_q, run, issue, step;

    assign done_o = cnt_q == 9'(SECTOR_WORDS);
    assign run    = (rd_i | wr_i) & ~done_o;
`ifdef SD_THROTTLE_EN
    logic ph_q;
    // issue a word on even cycles, advance the counter on odd ones
    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) ph_q <= 1'b0;
        else          ph_q <= start_i ? 1'b0 : run & ~ph_q;
    assign issue = run & ~ph_q;
    assign step  = run & ph_q;
`else
    assign issue = run;
    assign step  = run;
`endif
    assign cnt_d = cnt_q + 9'(step);
    // read: address follows the strobe; write: address shows the word being fetched
    assign addr_d = start_i ? 8'd0 :
                    (rd_i & issue) ? cnt_q[7:0] :
                    (wr_i & step & ~cnt_d[8]) ? cnt_d[7:0] : addr_q;

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            addr_q <= '0;
            p_q    <= 1'b0;
        end else begin
            cnt_q  <= start_i ? 9'd0 : cnt_d;
            idx_q  <= cnt_q[7:0];
            addr_q <= addr_d;
            p_q    <= issue & ~start_i;
        end

    assign st_rd_o     = rd_i & issue & ok_i;
    assign st_wr_o     = wr_i & p_q & ok_i;
    assign st_addr_o   = st_rd_o ? {lba_i, cnt_q[7:0]} : st_wr_o ? {lba_i, idx_q} : '0;
    assign st_wdata_o  = st_wr_o ? buff_din_i : 16'd0;
    assign buff_wr_o   = rd_i & p_q;
    assign buff_dout_o = buff_wr_o ? (ok_i ? st_rdata_i : FILL_WORD) : 16'd0;
    assign buff_addr_o = addr_q;
endmodule

// File: rtl/sd_block_responder.sv
// sd_block_responder: HPS-side SD sector responder backed by a word-addressed store.
// Define SD_THROTTLE_EN to pace transfers at one word every two cycles.
module sd_block_responder
    import sd_resp_pkg::*;
#(
    parameter int STORE_AW  = 12,
    parameter int ACK_DELAY = 4
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [31:0]         sd_lba,
    input  logic                sd_rd,
    input  logic                sd_wr,
    output logic                sd_ack,
    output logic [7:0]          sd_buff_addr,
    output logic [15:0]         sd_buff_dout,
    output logic                sd_buff_wr,
    input  logic [15:0]         sd_buff_din,
    output logic                img_mounted,
    output logic [63:0]         img_size,
    output logic                img_readonly,
    input  logic                mount_req,
    input  logic [63:0]         mount_size,
    input  logic                mount_ro,
    output logic [STORE_AW-1:0] st_addr,
    output logic                st_rd,
    output logic                st_wr,
    output logic [15:0]         st_wdata,
    input  logic [15:0]         st_rdata,
    output logic                busy
);
    sd_state_t           state_q, state_d;
    logic [STORE_AW-9:0] lba_q, lba_d;
    logic [3:0]          dly_q, dly_d;
    logic [63:0]         size_q, size_d;
    logic                dir_q, dir_d, ok_q, ok_d, ack_q, ack_d;
    logic                pend_q, pend_d, mreq_q, mph_q, mph_d, ro_q, ro_d;
    logic                rise, oor, start, pipe_done;

    assign rise = mount_req & ~mreq_q;
    assign oor  = |sd_lba[31:STORE_AW-8];

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        dir_d   = dir_q;
        ok_d    = ok_q;
        dly_d   = dly_q;
        pend_d  = pend_q | rise;
        mph_d   = 1'b0;
        size_d  = size_q;
        ro_d    = ro_q;
        start   = 1'b0;
        case (state_q)
            IDLE:
                if (pend_q | rise) begin
                    state_d = MNT;
                    pend_d  = 1'b0;
                end else if (sd_rd | sd_wr) begin
                    state_d = DELAY;
                    lba_d   = sd_lba[STORE_AW-9:0];
                    dir_d   = ~sd_rd;
                    ok_d    = ~oor & ~(~sd_rd & ro_q);
                    dly_d   = '0;
                end
            DELAY:
                if (dir_q ? ~sd_wr : ~sd_rd) state_d = IDLE;
                else if (dly_q == 4'(ACK_DELAY - 1)) begin
                    state_d = dir_q ? WR_XFER : RD_XFER;
                    start   = 1'b1;
                end else dly_d = dly_q + 4'd1;
            RD_XFER, WR_XFER: state_d = pipe_done ? DONE : state_q;
            DONE: state_d = IDLE;
            MNT:
                if (mph_q) state_d = IDLE;
                else begin
                    mph_d  = 1'b1;
                    size_d = mount_size;
                    ro_d   = mount_ro;
                end
            default: state_d = IDLE;
        endcase
        ack_d = state_d == RD_XFER || state_d == WR_XFER;
    end

    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            lba_q   <= '0;
            dir_q   <= 1'b0;
            ok_q    <= 1'b0;
            dly_q   <= '0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            mreq_q  <= 1'b0;
            mph_q   <= 1'b0;
            size_q  <= '0;
            ro_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            dir_q   <= dir_d;
            ok_q    <= ok_d;
            dly_q   <= dly_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            mreq_q  <= mount_req;
            mph_q   <= mph_d;
            size_q  <= size_d;
            ro_q    <= ro_d;
        end

    sd_word_pipe #(.AW(STORE_AW)) u_pipe (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start_i    (start),
        .rd_i       (state_q == RD_XFER),
        .wr_i       (state_q == WR_XFER),
        .ok_i       (ok_q),
        .lba_i      (lba_q),
        .st_rdata_i (st_rdata),
        .buff_din_i (sd_buff_din),
        .done_o     (pipe_done),
        .st_addr_o  (st_addr),
        .st_rd_o    (st_rd),
        .st_wr_o    (st_wr),
        .st_wdata_o (st_wdata),
        .buff_addr_o(sd_buff_addr),
        .buff_dout_o(sd_buff_dout),
        .buff_wr_o  (sd_buff_wr)
    );

    assign sd_ack       = ack_q;
    assign img_mounted  = state_q == MNT && mph_q;
    assign img_size     = size_q;
    assign img_readonly = ro_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_sd_block_responder.sv
// tb_sd_block_responder: directed scoreboard bench for sd_block_responder.
module tb_sd_block_responder;
    logic        clk_sys = 1'b0, reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic        sd_rd = 1'b0, sd_wr = 1'b0, mount_req = 1'b0, mount_ro = 1'b0;
    logic [63:0] mount_size = '0;
    logic [15:0] sd_buff_din = '0, st_rdata = '0, wbase = '0;
    logic        sd_ack, sd_buff_wr, img_mounted, img_readonly, st_rd, st_wr, busy;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, st_wdata;
    logic [63:0] img_size;
    logic [11:0] st_addr;

    logic [15:0] mem [0:4095];
    logic [4095:0] wrote = '0;
    logic [23:0] rq[$];
    logic [27:0] wq[$];
    int n_chk = 0, n_fail = 0, n_strobe = 0, n_strd = 0, n_stwr = 0, n_mnt = 0, n_ackr = 0;
    logic ack_prev = 1'b0;

    sd_block_responder #(.STORE_AW(12), .ACK_DELAY(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_mounted(img_mounted),
        .img_size(img_size), .img_readonly(img_readonly), .mount_req(mount_req),
        .mount_size(mount_size), .mount_ro(mount_ro), .st_addr(st_addr), .st_rd(st_rd),
        .st_wr(st_wr), .st_wdata(st_wdata), .st_rdata(st_rdata), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // unwritten store words read back as addr ^ A5A5; data is only valid after st_rd
    function automatic logic [15:0] rd_mem(input logic [11:0] a);
        return wrote[a] ? mem[a] : (16'(a) ^ 16'hA5A5);
    endfunction

    always @(posedge clk_sys) begin
        if (st_wr) begin
            mem[st_addr] <= st_wdata;
            wrote[st_addr] <= 1'b1;
        end
        st_rdata <= st_rd ? rd_mem(st_addr) : 16'h0BAD;
        sd_buff_din <= wbase + 16'(sd_buff_addr);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {5'b0, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, img_mounted, img_size,
                img_readonly, st_addr, st_rd, st_wr, st_wdata, busy};
    endfunction

    always @(negedge clk_sys) begin
        if (sd_buff_wr) begin
            n_strobe++;
            if (rq.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL rd_extra_strobe observed=%0h expected=none", sd_buff_dout);
            end else chk("rd_word", {sd_buff_addr, sd_buff_dout}, rq.pop_front());
        end
        if (st_wr) begin
            n_stwr++;
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL st_wr_extra observed=%0h expected=none", st_addr);
            end else chk("st_write", {st_addr, st_wdata}, wq.pop_front());
        end
        if (st_rd) n_strd++;
        if (img_mounted) n_mnt++;
        if (sd_ack && !ack_prev) n_ackr++;
        ack_prev = sd_ack;
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input int lim, output int cyc);
        cyc = 0;
        while (sd_ack !== lvl && cyc < lim) begin
            @(negedge clk_sys);
            cyc++;
        end
        chk(lvl ? "ack_rise" : "ack_fall", 128'(sd_ack), 128'(lvl));
    endtask

    task automatic push_rd(input logic [31:0] lba, input logic fill);
        for (int k = 0; k < 256; k++)
            rq.push_back({8'(k), fill ? 16'hFFFF : (16'(lba * 256 + k) ^ 16'hA5A5)});
    endtask

    // latency counts negedges from the drive point; ack rises ACK_DELAY edges after acceptance
    task automatic xfer(input logic wr, input logic [31:0] lba, output int lat);
        int fall;
        @(negedge clk_sys);
        sd_lba = lba;
        sd_rd = ~wr;
        sd_wr = wr;
        wait_ack(1'b1, 40, lat);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_ack(1'b0, 1200, fall);
    endtask

    initial begin
        int lat, bad, s0, r0, w0, m0, a0, cyc;
        settle(3);
        chk("reset_outputs", outs(), '0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        settle(2);
        chk("idle_busy", 128'(busy), 0);

        push_rd(3, 1'b0);
        s0 = n_strobe; r0 = n_strd;
        xfer(1'b0, 3, lat);
        chk("rd_ack_latency", 128'(lat), 5);
        settle(3);
        chk("rd_strobes", 128'(n_strobe - s0), 256);
        chk("rd_st_rd", 128'(n_strd - r0), 256);
        chk("rd_queue_drained", 128'(rq.size()), 0);
        chk("rd_busy_after", 128'(busy), 0);

        wbase = 16'h1000;
        for (int k = 0; k < 256; k++) wq.push_back({12'h100 + 12'(k), 16'h1000 + 16'(k)});
        w0 = n_stwr;
        xfer(1'b1, 1, lat);
        settle(3);
        chk("wr_st_wr_count", 128'(n_stwr - w0), 256);
        bad = 0;
        for (int k = 0; k < 256; k++) if (rd_mem(12'h100 + 12'(k)) !== 16'h1000 + 16'(k)) bad++;
        chk("wr_store_contents", 128'(bad), 0);

        m0 = n_mnt;
        @(negedge clk_sys);
        mount_size = 64'h2000;
        mount_ro = 1'b1;
        mount_req = 1'b1;
        settle(2);
        mount_req = 1'b0;
        settle(4);
        chk("mnt_pulses", 128'(n_mnt - m0), 1);
        chk("mnt_size", 128'(img_size), 128'h2000);
        chk("mnt_ro", 128'(img_readonly), 1);
        wbase = 16'h5000;
        w0 = n_stwr;
        xfer(1'b1, 0, lat);
        settle(3);
        chk("ro_st_wr_count", 128'(n_stwr - w0), 0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (rd_mem(12'(k)) !== (16'(k) ^ 16'hA5A5)) bad++;
        chk("ro_store_unchanged", 128'(bad), 0);

        push_rd(16, 1'b1);
        s0 = n_strobe; r0 = n_strd;
        xfer(1'b0, 16, lat);
        settle(3);
        chk("oor_strobes", 128'(n_strobe - s0), 256);
        chk("oor_st_rd", 128'(n_strd - r0), 0);

        a0 = n_ackr;
        @(negedge clk_sys);
        sd_lba = 3;
        sd_rd = 1'b1;
        settle(2);
        sd_rd = 1'b0;
        settle(10);
        chk("drop_no_ack", 128'(n_ackr - a0), 0);
        chk("drop_busy", 128'(busy), 0);

        push_rd(3, 1'b0);
        m0 = n_mnt;
        @(negedge clk_sys);
        sd_lba = 3;
        sd_rd = 1'b1;
        wait_ack(1'b1, 40, lat);
        sd_rd = 1'b0;
        settle(20);
        mount_size = 64'h4000;
        mount_ro = 1'b0;
        mount_req = 1'b1;
        settle(2);
        mount_req = 1'b0;
        wait_ack(1'b0, 1200, lat);
        chk("mnt_deferred", 128'(n_mnt - m0), 0);
        settle(6);
        chk("mnt_after_done", 128'(n_mnt - m0), 1);
        chk("mnt2_size", 128'(img_size), 128'h4000);
        chk("mnt2_ro", 128'(img_readonly), 0);

        push_rd(3, 1'b0);
        s0 = n_strobe;
        cyc = 0;
        @(negedge clk_sys);
        sd_lba = 3;
        sd_rd = 1'b1;
        while (n_strobe - s0 < 100 && cyc < 400) begin
            @(negedge clk_sys);
            cyc++;
        end
        sd_rd = 1'b0;
        chk("rst_reached_word100", 128'(n_strobe - s0), 100);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), '0);
        rq.delete();
        @(negedge clk_sys);
        reset_n = 1'b1;
        push_rd(3, 1'b0);
        s0 = n_strobe;
        xfer(1'b0, 3, lat);
        settle(3);
        chk("post_rst_latency", 128'(lat), 5);
        chk("post_rst_strobes", 128'(n_strobe - s0), 256);
        chk("final_queues", 128'(rq.size() + wq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Responder (HPS-side model) for the core's sector-based SD block interface: `sd_lba`, `sd_rd`/`sd_wr`, `sd_ack`, `sd_buff_*`.
- Services 512-byte (256×16-bit) sector reads and writes against a local word-addressed backing store.
- Signals image mounts to the core through `img_mounted`, `img_size` and `img_readonly`.
- Sits between the save-RAM initiator logic and a BRAM/SDRAM image store. Used in simulation benches and standalone builds with no HPS.

Parameters:
- `STORE_AW`, 12: backing-store word address width; store word address = {lba[STORE_AW-9:0], word[7:0]}.
- `ACK_DELAY`, 4: cycles from request acceptance to `sd_ack` rise; valid range 1..15.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sd_lba` in 32: sector number, sampled at request acceptance.
- `sd_rd` in 1: read request, level; host to core.
- `sd_wr` in 1: write request, level; core to host.
- `sd_ack` out 1: high for the whole sector transfer.
- `sd_buff_addr` out 8: word index within the sector.
- `sd_buff_dout` out 16: read data to the core.
- `sd_buff_wr` out 1: strobe; `sd_buff_dout` is valid at `sd_buff_addr`.
- `sd_buff_din` in 16: write data from the core; 1-cycle latency after `sd_buff_addr`.
- `img_mounted` out 1: one-cycle mount pulse.
- `img_size` out 64: image size in bytes.
- `img_readonly` out 1: image is write-protected.
- `mount_req` in 1: rising edge requests a mount.
- `mount_size` in 64: size to publish at mount.
- `mount_ro` in 1: read-only flag to publish at mount.
- `st_addr` out `STORE_AW`: backing-store word address.
- `st_rd` out 1: store read; `st_rdata` is valid exactly 1 cycle later.
- `st_wr` out 1: store write strobe.
- `st_wdata` out 16: store write data.
- `st_rdata` in 16: store read data.
- `busy` out 1: state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-transfer aborts immediately; the store is left with partial contents.

State machine: IDLE, DELAY, RD_XFER, WR_XFER, DONE, MNT.
- IDLE:
  - Pending mount takes priority over a request: go to MNT.
  - Else if (`sd_rd` | `sd_wr`): latch `sd_lba` and direction, then go to DELAY. `sd_rd` wins if both are high.
- DELAY:
  - Counts `ACK_DELAY` cycles, then sets `sd_ack`=1 and enters RD_XFER or WR_XFER.
  - If the latched request line drops during DELAY, return to IDLE with no ack.
- RD_XFER (pipelined, 1 word/cycle):
  - Cycle k (0..255): `st_rd`=1, `st_addr`={lba_lo,k}.
  - Cycle k+1: `sd_buff_wr`=1, `sd_buff_addr`=k, `sd_buff_dout`=`st_rdata`.
  - Last strobe at k=255 (cycle 256), then go to DONE.
- WR_XFER:
  - Cycle k: `sd_buff_addr`=k.
  - Cycle k+1: `st_wr`=1, `st_addr`={lba_lo,k}, `st_wdata`=`sd_buff_din`.
  - 257 cycles total, then go to DONE.
- DONE: drop `sd_ack` for one cycle minimum, then go to IDLE. A new request is accepted no earlier than the following cycle.
- Out of range (`sd_lba` ≥ 2^(`STORE_AW`-8)), or writes while `img_readonly`=1:
  - Full handshake and timing are still performed.
  - Reads return 16'hFFFF with `st_rd`=0.
  - Writes are discarded with `st_wr`=0.
- Mount:
  - A `mount_req` rising edge sets a pending flag; it is deferred until IDLE.
  - MNT cycle 1: latch `mount_size`/`mount_ro` into `img_size`/`img_readonly`.
  - MNT cycle 2: `img_mounted`=1 for one cycle, then go to IDLE.
  - A second edge while pending is merged with the first.
- `sd_buff_addr` wraps 255→0 only at a new transfer; it holds its last value otherwise.

Optional Feature:
- Macro: `SD_THROTTLE_EN`.
- Defined:
  - One idle cycle is inserted between words in both directions, emulating HPS pacing.
  - RD: `sd_buff_wr` strobes are on alternate cycles.
  - WR: `sd_buff_addr` advances every 2 cycles; `sd_buff_din` is sampled 1 cycle after each address change.
  - Transfer length is about 512 cycles.
- Undefined: 1 word/cycle as described above.

Decomposition:
- Package `sd_resp_pkg`: state enum `sd_state_t`, `SECTOR_WORDS`=256, `FILL_WORD`=16'hFFFF.
- Sub-module `sd_word_pipe`: handles word counter, throttle gating and the 1-cycle store/buffer alignment for both directions. The top module keeps the FSM and mount logic.

Test Plan:
- Preload store sector 3 with word=addr^16'hA5A5; pulse `sd_lba`=3, `sd_rd`=1 (dropped on ack rise) -> `sd_ack` rises 4 cycles after acceptance; 256 `sd_buff_wr` strobes with `sd_buff_dout`[k]=(0x300+k)^0xA5A5; ack falls.
- `sd_wr`, `sd_lba`=1, core buffer q = 16'h1000+k -> store words 0x100..0x1FF equal 0x1000..0x10FF; `st_wr` count = 256.
- `mount_req` edge with size 0x2000, ro=1, then `sd_wr` lba 0 -> `img_mounted` pulse once; write completes handshake with zero `st_wr`; store unchanged.
- Read `sd_lba`=16 with `STORE_AW`=12 -> 256 strobes of 16'hFFFF, `st_rd` never high.
- `sd_rd` raised then dropped at DELAY cycle 2 -> no `sd_ack`, `busy` returns 0; `mount_req` during RD_XFER -> `img_mounted` only after DONE→IDLE.
- `reset_n` low at word 100 of a read -> all outputs 0 asynchronously; a subsequent read of lba 3 completes correctly.
